// File: rtl/ascon_out_collector.sv
// Capture stage for the AEAD core byte stream: FIFO buffer, per-frame XOR checksum
// and byte count, and a registered request/valid read port for the host.
module ascon_out_collector #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    core_data,
    input  logic          core_ready,
    input  logic          core_done,
    input  logic          rd_req,
    input  logic          clear,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic [AW:0]   fifo_count,
    output logic          empty,
    output logic          full,
    output logic          overflow,
    output logic          frame_done,
    output logic [7:0]    checksum,
    output logic [7:0]    byte_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    state_t         r_state;
    state_t         w_next_state;

    logic [7:0]     r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;
    logic [7:0]     r_rd_data;
    logic           r_rd_valid;
    logic           r_overflow;
    logic [7:0]     r_checksum;
    logic [7:0]     r_byte_cnt;

    logic           w_empty;
    logic           w_full;
    logic           w_push_req;
    logic           w_pop;
    logic           w_push;
    logic           w_drop;

    // Flags decode only the registered count, never the same-cycle requests.
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == FULL_CNT);

    assign w_push_req = !clear && core_ready && (r_state != DONE);
    assign w_pop      = !clear && rd_req && !w_empty;
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    // NOTE: every output of an always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (core_ready) w_next_state = COLLECT;
            COLLECT: if (core_done)  w_next_state = DONE;
            DONE:    w_next_state = DONE;
            default: w_next_state = IDLE;
        endcase
        if (clear) w_next_state = IDLE;
    end

    // NOTE: sequential state uses non-blocking (<=) so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // NOTE: the storage array has no reset; occupancy and pointers alone define its valid contents.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= core_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_data  <= 8'h00;
            r_rd_valid <= 1'b0;
            r_overflow <= 1'b0;
            r_checksum <= 8'h00;
            r_byte_cnt <= 8'h00;
        end else if (clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_valid <= 1'b0;
            r_overflow <= 1'b0;
            r_checksum <= 8'h00;
            r_byte_cnt <= 8'h00;
        end else begin
            r_rd_valid <= w_pop;
            // On full push+pop both pointers match; the read sees the old entry.
            if (w_pop) begin
                r_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + 1'b1;
            end
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + 1'b1;
                r_checksum <= r_checksum ^ core_data;
                if (r_byte_cnt != 8'hFF) r_byte_cnt <= r_byte_cnt + 8'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    assign rd_data    = r_rd_data;
    assign rd_valid   = r_rd_valid;
    assign fifo_count = r_count;
    assign empty      = w_empty;
    assign full       = w_full;
    assign overflow   = r_overflow;
    assign frame_done = (r_state == DONE);
    assign checksum   = r_checksum;
    assign byte_cnt   = r_byte_cnt;

endmodule

// File: tb/tb_ascon_out_collector.sv
// Directed bench for ascon_out_collector: a cycle vector table plus hand-written
// sequences for overflow, full/empty push+pop, frame end, pointer wrap and async reset.
module tb_ascon_out_collector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] core_data;
    logic       core_ready;
    logic       core_done;
    logic       rd_req;
    logic       clear;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [4:0] fifo_count;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       frame_done;
    logic [7:0] checksum;
    logic [7:0] byte_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ascon_out_collector #(.DEPTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .core_data  (core_data),
        .core_ready (core_ready),
        .core_done  (core_done),
        .rd_req     (rd_req),
        .clear      (clear),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .fifo_count (fifo_count),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow),
        .frame_done (frame_done),
        .checksum   (checksum),
        .byte_cnt   (byte_cnt)
    );

    typedef struct {
        logic [7:0] data;
        logic       rdy;
        logic       done;
        logic       req;
        logic       clr;
        logic [7:0] e_rd;
        logic       e_v;
        logic [4:0] e_cnt;
        logic [7:0] e_cs;
        logic [7:0] e_bc;
        logic       e_fd;
        logic       e_ov;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive inputs away from the sampling edge, then settle just after it.
    task automatic step(input logic [7:0] d, input logic rdy, input logic dn,
                        input logic req, input logic clr);
        @(negedge clk);
        core_data  = d;
        core_ready = rdy;
        core_done  = dn;
        rd_req     = req;
        clear      = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag, input logic [7:0] exp_rd);
        check({tag, " rd_data"},    32'(rd_data),    32'(exp_rd));
        check({tag, " rd_valid"},   32'(rd_valid),   0);
        check({tag, " fifo_count"}, 32'(fifo_count), 0);
        check({tag, " empty"},      32'(empty),      1);
        check({tag, " full"},       32'(full),       0);
        check({tag, " overflow"},   32'(overflow),   0);
        check({tag, " frame_done"}, 32'(frame_done), 0);
        check({tag, " checksum"},   32'(checksum),   0);
        check({tag, " byte_cnt"},   32'(byte_cnt),   0);
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] prev;

        rst_n      = 1'b0;
        core_data  = 8'h00;
        core_ready = 1'b0;
        core_done  = 1'b0;
        rd_req     = 1'b0;
        clear      = 1'b0;
        #12;
        check_reset_outputs("reset", 8'h00);
        rst_n = 1'b1;

        // Basic capture/drain, empty read, empty push+pop, then clear.
        //            data   rdy   done  req   clr   e_rd   e_v   cnt   cs     bc    fd    ov
        vecs[0]  = '{8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd1, 8'h11, 8'd1, 1'b0, 1'b0};
        vecs[1]  = '{8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd2, 8'h33, 8'd2, 1'b0, 1'b0};
        vecs[2]  = '{8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd3, 8'h00, 8'd3, 1'b0, 1'b0};
        vecs[3]  = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11, 1'b1, 5'd2, 8'h00, 8'd3, 1'b0, 1'b0};
        vecs[4]  = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h22, 1'b1, 5'd1, 8'h00, 8'd3, 1'b0, 1'b0};
        vecs[5]  = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h33, 1'b1, 5'd0, 8'h00, 8'd3, 1'b0, 1'b0};
        vecs[6]  = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h33, 1'b0, 5'd0, 8'h00, 8'd3, 1'b0, 1'b0};
        vecs[7]  = '{8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 8'h33, 1'b0, 5'd1, 8'h5A, 8'd4, 1'b0, 1'b0};
        vecs[8]  = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b1, 5'd0, 8'h5A, 8'd4, 1'b0, 1'b0};
        vecs[9]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 5'd0, 8'h5A, 8'd4, 1'b0, 1'b0};
        vecs[10] = '{8'h77, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 5'd0, 8'h00, 8'd0, 1'b0, 1'b0};

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].data, vecs[i].rdy, vecs[i].done, vecs[i].req, vecs[i].clr);
            check($sformatf("v%0d rd_data", i),    32'(rd_data),    32'(vecs[i].e_rd));
            check($sformatf("v%0d rd_valid", i),   32'(rd_valid),   32'(vecs[i].e_v));
            check($sformatf("v%0d fifo_count", i), 32'(fifo_count), 32'(vecs[i].e_cnt));
            check($sformatf("v%0d empty", i),      32'(empty),      32'(vecs[i].e_cnt == 5'd0));
            check($sformatf("v%0d checksum", i),   32'(checksum),   32'(vecs[i].e_cs));
            check($sformatf("v%0d byte_cnt", i),   32'(byte_cnt),   32'(vecs[i].e_bc));
            check($sformatf("v%0d frame_done", i), 32'(frame_done), 32'(vecs[i].e_fd));
            check($sformatf("v%0d overflow", i),   32'(overflow),   32'(vecs[i].e_ov));
        end

        // Overflow: 17 pushes into 16 entries, the 17th (0x10) is dropped.
        for (int i = 0; i < 17; i++) step(8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        check("ovf full",       32'(full),       1);
        check("ovf overflow",   32'(overflow),   1);
        check("ovf fifo_count", 32'(fifo_count), 16);
        check("ovf byte_cnt",   32'(byte_cnt),   16);
        check("ovf checksum",   32'(checksum),   0);
        for (int i = 0; i < 16; i++) begin
            step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
            check($sformatf("ovf drain %0d data", i), 32'(rd_data), i);
            check($sformatf("ovf drain %0d valid", i), 32'(rd_valid), 1);
        end
        idle();
        check("ovf drained empty", 32'(empty), 1);

        // Full with push+pop: count holds, no overflow, 0xAB comes out last.
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) step(8'h80 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        check("fpp full before", 32'(full), 1);
        step(8'hAB, 1'b1, 1'b0, 1'b1, 1'b0);
        check("fpp rd_data",    32'(rd_data),    32'h80);
        check("fpp fifo_count", 32'(fifo_count), 16);
        check("fpp overflow",   32'(overflow),   0);
        for (int i = 1; i < 17; i++) begin
            step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
            check($sformatf("fpp drain %0d", i), 32'(rd_data), (i == 16) ? 32'hAB : 32'h80 + i);
        end
        check("fpp checksum", 32'(checksum), 32'hAB);
        check("fpp byte_cnt", 32'(byte_cnt), 17);

        // Frame end: 8 bytes, 9th with core_done, then two ignored bytes.
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 8; i++) step(8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        check("frm not done yet", 32'(frame_done), 0);
        step(8'h09, 1'b1, 1'b1, 1'b0, 1'b0);
        check("frm frame_done", 32'(frame_done), 1);
        check("frm byte_cnt",   32'(byte_cnt),   9);
        check("frm checksum",   32'(checksum),   32'h01);
        step(8'hEE, 1'b1, 1'b0, 1'b0, 1'b0);
        step(8'hEF, 1'b1, 1'b0, 1'b0, 1'b0);
        check("frm ignored byte_cnt",   32'(byte_cnt),   9);
        check("frm ignored fifo_count", 32'(fifo_count), 9);
        check("frm ignored checksum",   32'(checksum),   32'h01);
        check("frm overflow",           32'(overflow),   0);
        check("frm still done",         32'(frame_done), 1);
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        check_reset_outputs("frm clear", 8'hAB);

        // Interleaved push/pop of 40 bytes: pointers wrap twice, order preserved.
        step(8'h03, 1'b1, 1'b0, 1'b0, 1'b0);
        prev = 8'h03;
        for (int i = 1; i < 40; i++) begin
            d = 8'(i * 7 + 3);
            step(d, 1'b1, 1'b0, 1'b1, 1'b0);
            check($sformatf("wrap %0d data", i - 1), 32'(rd_data), 32'(prev));
            check($sformatf("wrap %0d count", i - 1), 32'(fifo_count), 1);
            prev = d;
        end
        step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        check("wrap 39 data",  32'(rd_data),  32'(prev));
        check("wrap byte_cnt", 32'(byte_cnt), 40);

        // Async reset mid-stream, checked before any further clock edge.
        step(8'hC1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(8'hC2, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        core_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async rst", 8'h00);
        #1;
        rst_n = 1'b1;
        idle();
        check("post rst empty", 32'(empty), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
